// File: rtl/uart_op_pkg.sv
// Shared types and sizing helpers for the UART operand sequencer.
package uart_op_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    LAUNCH,
    WAIT,
    SEND
  } op_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Number of bytes carried by a W-bit operand or result.
  function automatic int unsigned nb_of(input int unsigned w);
    return w / 8;
  endfunction

  // Width of the shared timeout counter, sized for the larger of the two limits.
  function automatic int unsigned ctr_width(input int unsigned gap_to,
                                            input int unsigned res_to);
    int unsigned m;
    m = (gap_to > res_to) ? gap_to : res_to;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_op_sequencer_ctr.sv
// Loadable up-counter with clear and terminal-count flag; serves both the
// inter-byte gap timeout and the result timeout since they never overlap.
module op_timeout_ctr #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] limit,
  output logic          tc_c
);

  logic [CW-1:0] count_q;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Flag the cycle whose increment would reach the limit.
  assign tc_c = en && (({1'b0, count_q} + (CW+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/uart_op_sequencer.sv
// Collects a sync-framed operand from the UART, launches one datapath
// operation, then streams the result back big-endian one byte per TX handshake.
module uart_op_sequencer
  import uart_op_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned GAP_TIMEOUT = 1_000_000,
  parameter int unsigned RES_TIMEOUT = 4096
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   RX_DATA,
  input  logic         RX_DONE,
  output logic [7:0]   TX_DATA,
  output logic         TX_START,
  input  logic         TX_DONE,
  output logic [W-1:0] OP_DATA,
  output logic         OP_START,
  input  logic [W-1:0] RES_DATA,
  input  logic         RES_READY,
  output logic         BUSY,
  output logic         ERR,
  output logic         DROP
);

  localparam int unsigned NB  = nb_of(W);
  localparam int unsigned BCW = $clog2(NB) + 1;
  localparam int unsigned CW  = ctr_width(GAP_TIMEOUT, RES_TIMEOUT);

  op_state_t      state_q, state_d;
  logic [W-1:0]   operand_q, operand_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   shifted;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     tx_data_d;
  logic [W-1:0]   op_data_d;
  logic           tx_start_d, op_start_d, err_d, drop_d;
  logic           ctr_load, ctr_en, ctr_clr, ctr_tc;
  logic [CW-1:0]  ctr_limit;

  // Only one timeout is live at a time; pick its limit by state.
  assign ctr_limit = (state_q == WAIT) ? CW'(RES_TIMEOUT) : CW'(GAP_TIMEOUT);

  op_timeout_ctr #(.CW(CW)) u_ctr (
    .clk      (CLK),
    .rst      (RST),
    .clr      (ctr_clr),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (CW'(1)),
    .limit    (ctr_limit),
    .tc_c     (ctr_tc)
  );

  // State and datapath register update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      result_q   <= '0;
      byte_cnt_q <= '0;
      TX_DATA    <= '0;
      TX_START   <= 1'b0;
      OP_DATA    <= '0;
      OP_START   <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
      DROP       <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      result_q   <= result_d;
      byte_cnt_q <= byte_cnt_d;
      TX_DATA    <= tx_data_d;
      TX_START   <= tx_start_d;
      OP_DATA    <= op_data_d;
      OP_START   <= op_start_d;
      BUSY       <= (state_d != IDLE);
      ERR        <= err_d;
      DROP       <= drop_d;
    end
  end

  // Next-state and next-output logic; the counter is reloaded to 1 on every
  // restarting event so ERR lands exactly TIMEOUT cycles after that event.
  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    result_d   = result_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = TX_DATA;
    op_data_d  = OP_DATA;
    tx_start_d = 1'b0;
    op_start_d = 1'b0;
    err_d      = 1'b0;
    drop_d     = 1'b0;
    ctr_load   = 1'b0;
    ctr_en     = 1'b0;
    shifted    = result_q << 8;

    case (state_q)
      IDLE: begin
        if (RX_DONE && (RX_DATA == SYNC_BYTE)) begin
          state_d    = RECV;
          byte_cnt_d = '0;
          operand_d  = '0;
          ctr_load   = 1'b1;
        end
      end

      RECV: begin
        ctr_en = 1'b1;
        if (RX_DONE) begin
          operand_d = (operand_q << 8) | W'(RX_DATA);
          ctr_load  = 1'b1;
          if (byte_cnt_q == BCW'(NB - 1)) begin
            state_d    = LAUNCH;
            op_start_d = 1'b1;
            op_data_d  = operand_d;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end else if (ctr_tc) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          operand_d = '0;
        end
      end

      LAUNCH: begin
        state_d  = WAIT;
        ctr_load = 1'b1;
        drop_d   = RX_DONE;
      end

      WAIT: begin
        ctr_en = 1'b1;
        drop_d = RX_DONE;
        if (RES_READY) begin
          state_d    = SEND;
          result_d   = RES_DATA;
          tx_data_d  = RES_DATA[W-1 -: 8];
          tx_start_d = 1'b1;
          byte_cnt_d = '0;
        end else if (ctr_tc) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end

      SEND: begin
        drop_d = RX_DONE;
        if (TX_DONE) begin
          if (byte_cnt_q == BCW'(NB - 1)) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
          end else begin
            result_d   = shifted;
            tx_data_d  = shifted[W-1 -: 8];
            tx_start_d = 1'b1;
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep the counter parked at zero while idle.
    ctr_clr = (state_q == IDLE) && !ctr_load;
  end

endmodule
